axis2raw_burst: RTL and testbench
=================================

Name: axis2raw_burst

Overview:
- Parametrised successor to the single-threshold AXI-Stream-to-raw converter.
- Buffers a gappy AXI-Stream pixel stream in an internal circular buffer, then releases it as a gap-free raw burst (one word per clk, no backpressure) once a start level is reached.
- Unlike the previous generation, it:
  - flushes on end-of-line (tlast), so short lines and frame tails are never stranded;
  - forwards frame/line markers alongside the data;
  - has parametrised pixel and line counters;
  - exposes fill level.
- Sits between the camera/DMA AXIS source and the raw-pixel feature pipeline.

Parameters:
- DATA_WIDTH, 8, pixel word width.
- ADDR_WIDTH, 13, buffer depth = 2**ADDR_WIDTH words.
- START_LEVEL, 8000, stored-word count that triggers a burst. Must be in 1..2**ADDR_WIDTH.
- PCNT_WIDTH, 20, width of the pixel counter.
- LCNT_WIDTH, 11, width of the line counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DATA_WIDTH  input pixel.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  end of line.
- s_axis_tuser  in  1  start of frame.
- raw_data  out  DATA_WIDTH  output pixel.
- raw_valid  out  1  output qualifier.
- raw_sof  out  1  raw_data is the first pixel of a frame.
- raw_eol  out  1  raw_data is the last pixel of a line.
- pcnt  out  PCNT_WIDTH  pixels emitted in the current frame.
- lcnt  out  LCNT_WIDTH  lines completed in the current frame.
- level  out  ADDR_WIDTH+1  words currently stored.
- overflow  out  1  sticky drop flag.

Behaviour:
- Reset (async assert on rst_n=0, sync release): all outputs and internal state go to 0; FSM goes to FILL.
- Storage: each word is stored as {tuser, tlast, tdata}.
  - Write (push) when s_axis_tvalid && s_axis_tready.
  - Synchronous-read RAM; wr_ptr and rd_ptr are ADDR_WIDTH bits and wrap modulo depth.
  - level counts 0..2**ADDR_WIDTH. full = (level == 2**ADDR_WIDTH); empty = (level == 0).
- Simultaneous push and pop: level is unchanged.
- Pop is the read enable. The popped word appears on raw_data/raw_sof/raw_eol with raw_valid=1 exactly one cycle after the pop; latency is 1.
- When raw_valid=0: raw_data holds its last value; raw_sof and raw_eol are 0.
- last_pend counter: +1 when a word with tlast is pushed, -1 when one is popped. Both in the same cycle leaves it unchanged.
- FSM:
  - FILL:
    - No pop.
    - If level >= START_LEVEL, go to BURST.
    - Else if last_pend != 0, go to FLUSH.
    - Evaluated on registered level each cycle.
  - BURST:
    - Pop every cycle while the buffer is not empty.
    - When the buffer becomes empty (level==1 popped with no push, or level==0), return to FILL.
  - FLUSH:
    - Pop every cycle.
    - When the popped word has tlast and last_pend becomes 0:
      - go to BURST if the remaining level >= START_LEVEL;
      - otherwise go to FILL.
- Burst contiguity: within a burst, raw_valid stays high on consecutive cycles. There is no downstream ready; the consumer must always accept.
- s_axis_tready = !full (default build).
- Counters, updated on emitted words:
  - Emitted word with sof: pcnt <= 1, lcnt <= 0.
  - Other emitted words: pcnt <= pcnt+1, saturating at all-ones.
  - Emitted word with eol: lcnt <= lcnt+1, wrapping.
- Reset mid-burst: buffer contents are discarded, and the next frame restarts cleanly.

Optional Feature:
- Macro: AXIS2RAW_NOBP_EN.
- Defined:
  - s_axis_tready is tied to 1.
  - A word arriving while full is dropped and sets overflow=1, sticky until reset.
  - last_pend is not incremented for a dropped word.
- Undefined:
  - Backpressure via s_axis_tready = !full.
  - overflow is constant 0.

Test Plan:
- Threshold burst:
  - Stimulus: ADDR_WIDTH=4, START_LEVEL=8. Push 8 words (0x10..0x17) with random valid gaps and no tlast.
  - Required response: raw_valid asserts 8 consecutive cycles with 0x10..0x17 in order; level returns to 0; FSM returns to FILL.
- Short-line flush:
  - Stimulus: push 3 words, the third with tlast; START_LEVEL=8.
  - Required response: the 3 words are emitted back-to-back; raw_eol=1 on the third; lcnt=1.
- Frame markers:
  - Stimulus: tuser on word 0, two lines of 4 words each.
  - Required response: raw_sof on the first output; pcnt=8 and lcnt=2 after the last output; a new tuser resets pcnt to 1 and lcnt to 0.
- Full/backpressure:
  - Stimulus: default build, depth 16, START_LEVEL=16, push 20 words continuously.
  - Required response: s_axis_tready drops while level=16; all 20 words are emitted in order; overflow stays 0.
- Drop mode:
  - Stimulus: AXIS2RAW_NOBP_EN defined, same stimulus as the full/backpressure test, output stalled by full threshold.
  - Required response: words arriving while full are dropped, overflow=1, and the sequence has no duplicates.
- Async reset mid-burst:
  - Stimulus: pull rst_n low during BURST.
  - Required response: raw_valid=0, level=0 and pcnt=0 immediately; a fresh 8-word fill after release bursts correctly.

Source files
------------

// File: rtl/axis2raw_burst.sv
// AXI-Stream to gap-free raw burst converter with circular buffer, end-of-line flush and frame
// counters. Define AXIS2RAW_NOBP_EN to tie s_axis_tready high and drop words while full.
module axis2raw_burst #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 13,
    parameter int unsigned START_LEVEL = 8000,
    parameter int unsigned PCNT_WIDTH  = 20,
    parameter int unsigned LCNT_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [DATA_WIDTH-1:0] raw_data,
    output logic                  raw_valid,
    output logic                  raw_sof,
    output logic                  raw_eol,
    output logic [PCNT_WIDTH-1:0] pcnt,
    output logic [LCNT_WIDTH-1:0] lcnt,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LVL_FULL  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LVL_START = (ADDR_WIDTH + 1)'(START_LEVEL);
    localparam logic [ADDR_WIDTH:0] LVL_ONE   = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {StFill, StBurst, StFlush} state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH+1:0]   mem [DEPTH];
    logic [DEPTH-1:0]        last_bits;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]     level_q, level_d, last_pend_q, last_pend_d, push_ext;
    logic [DATA_WIDTH+1:0]   out_q;
    logic                    valid_q, ovf_q;
    logic [PCNT_WIDTH-1:0]   pcnt_q;
    logic [LCNT_WIDTH-1:0]   lcnt_q, lcnt_base;
    logic                    full, empty, push, pop, drop, push_last, pop_last, head_last;

    assign full      = (level_q == LVL_FULL);
    assign empty     = (level_q == '0);
    assign push      = s_axis_tvalid && !full;
    assign push_last = push && s_axis_tlast;
    assign push_ext  = {{ADDR_WIDTH{1'b0}}, push};
    // tlast of the head word is needed in the pop cycle, ahead of the registered read
    assign head_last = last_bits[rd_ptr_q];
    assign pop_last  = pop && head_last;

`ifdef AXIS2RAW_NOBP_EN
    assign s_axis_tready = 1'b1;
    assign drop          = s_axis_tvalid && full;
`else
    assign s_axis_tready = !full;
    assign drop          = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            StFill: begin
                if (level_q >= LVL_START) state_d = StBurst;
                else if (last_pend_q != '0) state_d = StFlush;
            end
            StBurst: begin
                pop = !empty;
                if (empty || (level_q == LVL_ONE && !push)) state_d = StFill;
            end
            StFlush: begin
                pop = !empty;
                if (empty) begin
                    state_d = StFill;
                end else if (head_last && last_pend_q == LVL_ONE && !push_last) begin
                    state_d = (level_q - LVL_ONE + push_ext >= LVL_START) ? StBurst : StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_comb begin
        level_d     = level_q;
        last_pend_d = last_pend_q;
        if (push && !pop) level_d = level_q + LVL_ONE;
        else if (!push && pop) level_d = level_q - LVL_ONE;
        if (push_last && !pop_last) last_pend_d = last_pend_q + LVL_ONE;
        else if (!push_last && pop_last) last_pend_d = last_pend_q - LVL_ONE;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q]       <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
            last_bits[wr_ptr_q] <= s_axis_tlast;
        end
    end

    // A start-of-frame word restarts the line count before its own eol is applied
    assign lcnt_base = out_q[DATA_WIDTH+1] ? '0 : lcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StFill;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            last_pend_q <= '0;
            out_q       <= '0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
            pcnt_q      <= '0;
            lcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_q + ADDR_WIDTH'(push);
            rd_ptr_q    <= rd_ptr_q + ADDR_WIDTH'(pop);
            level_q     <= level_d;
            last_pend_q <= last_pend_d;
            valid_q     <= pop;
            ovf_q       <= ovf_q | drop;
            if (pop) out_q <= mem[rd_ptr_q];
            if (valid_q) begin
                if (out_q[DATA_WIDTH+1]) pcnt_q <= PCNT_WIDTH'(1);
                else if (pcnt_q != '1) pcnt_q <= pcnt_q + PCNT_WIDTH'(1);
                lcnt_q <= lcnt_base + LCNT_WIDTH'(out_q[DATA_WIDTH]);
            end
        end
    end

    assign raw_data  = out_q[DATA_WIDTH-1:0];
    assign raw_valid = valid_q;
    assign raw_sof   = valid_q && out_q[DATA_WIDTH+1];
    assign raw_eol   = valid_q && out_q[DATA_WIDTH];
    assign pcnt      = pcnt_q;
    assign lcnt      = lcnt_q;
    assign level     = level_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_axis2raw_burst.sv
// Self-checking bench for axis2raw_burst: scoreboard of pushed words against raw output,
// table-driven frame-marker vectors, and hand-written threshold/flush/full/reset sequences.
module tb_axis2raw_burst;

    typedef struct {
        logic [7:0]  data;
        logic        last;
        logic        user;
        logic [19:0] pcnt;
        logic [10:0] lcnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  a_tdata, b_tdata, a_raw_data, b_raw_data;
    logic        a_tvalid, a_tready, a_tlast, a_tuser, a_raw_valid, a_raw_sof, a_raw_eol, a_ovf;
    logic        b_tvalid, b_tready, b_tlast, b_tuser, b_raw_valid, b_raw_sof, b_raw_eol, b_ovf;
    logic [19:0] a_pcnt, b_pcnt;
    logic [10:0] a_lcnt, b_lcnt;
    logic [4:0]  a_level, b_level;

    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t pe;
    exp_t frame_tab[10];
    bit   pend_a = 0;
    int   run_a = 0, last_run_a = 0;
    logic [19:0] mpa = 0;
    logic [10:0] mla = 0;
    bit   saw_b_stall = 0, seen_b = 0;
    int   nb = 0;
    logic [7:0] last_b = 0;

    always #5 clk = ~clk;

    axis2raw_burst #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .START_LEVEL(8), .PCNT_WIDTH(20),
                     .LCNT_WIDTH(11)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_axis_tdata(a_tdata), .s_axis_tvalid(a_tvalid),
        .s_axis_tready(a_tready), .s_axis_tlast(a_tlast), .s_axis_tuser(a_tuser),
        .raw_data(a_raw_data), .raw_valid(a_raw_valid), .raw_sof(a_raw_sof),
        .raw_eol(a_raw_eol), .pcnt(a_pcnt), .lcnt(a_lcnt), .level(a_level), .overflow(a_ovf)
    );

    axis2raw_burst #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .START_LEVEL(16), .PCNT_WIDTH(20),
                     .LCNT_WIDTH(11)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid),
        .s_axis_tready(b_tready), .s_axis_tlast(b_tlast), .s_axis_tuser(b_tuser),
        .raw_data(b_raw_data), .raw_valid(b_raw_valid), .raw_sof(b_raw_sof),
        .raw_eol(b_raw_eol), .pcnt(b_pcnt), .lcnt(b_lcnt), .level(b_level), .overflow(b_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference counter model: sof restarts the frame, eol completes a line
    task automatic model_a(input logic u, input logic l, output logic [19:0] p,
                           output logic [10:0] lc);
        if (u) begin
            p  = 20'd1;
            lc = 11'd0;
        end else begin
            p  = (mpa == 20'hFFFFF) ? mpa : mpa + 20'd1;
            lc = mla;
        end
        if (l) lc = lc + 11'd1;
        mpa = p;
        mla = lc;
    endtask

    task automatic push_a(input logic [7:0] d, input logic l, input logic u,
                          input logic [19:0] ep, input logic [10:0] el, input int gap);
        exp_t e;
        bit   ok;
        int   n;
        n = 0;
        repeat (gap) begin @(posedge clk); #1; end
        a_tdata = d; a_tlast = l; a_tuser = u; a_tvalid = 1'b1;
        forever begin
            ok = a_tready;
            @(posedge clk); #1;
            if (ok) break;
            n++;
            if (n > 200) begin
                errors++; checks++;
                $display("FAIL push_a_timeout: data 0x%0h not accepted, required acceptance", d);
                break;
            end
        end
        a_tvalid = 1'b0; a_tlast = 1'b0; a_tuser = 1'b0;
        if (ok) begin
            e = '{d, l, u, ep, el};
            qa.push_back(e);
        end
    endtask

    task automatic push_am(input logic [7:0] d, input logic l, input logic u, input int gap);
        logic [19:0] p;
        logic [10:0] lc;
        model_a(u, l, p, lc);
        push_a(d, l, u, p, lc, gap);
    endtask

    task automatic push_b(input logic [7:0] d);
        exp_t e;
        bit   ok;
        int   n;
        n = 0;
        b_tdata = d; b_tlast = 1'b0; b_tuser = 1'b0; b_tvalid = 1'b1;
        forever begin
            ok = b_tready;
            @(posedge clk); #1;
            if (ok) break;
            n++;
            if (n > 200) begin
                errors++; checks++;
                $display("FAIL push_b_timeout: data 0x%0h not accepted, required acceptance", d);
                break;
            end
        end
        b_tvalid = 1'b0;
`ifndef AXIS2RAW_NOBP_EN
        if (ok) begin
            e = '{d, 1'b0, 1'b0, 20'd0, 11'd0};
            qb.push_back(e);
        end
`endif
    endtask

    task automatic drain_a();
        int n;
        n = 0;
        while (qa.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
        if (qa.size() != 0) begin
            errors++; checks++;
            $display("FAIL drain_a_timeout: %0d words still pending, required 0", qa.size());
            qa.delete();
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic drain_b();
        int n;
        n = 0;
        while ((qb.size() != 0 || b_level != 0 || b_raw_valid) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_b_level", 32'(b_level), 32'd0);
        qb.delete();
        repeat (3) begin @(posedge clk); #1; end
    endtask

    // Monitor A: order, data and markers per word; counters one cycle after each word
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_a = 0;
            run_a  = 0;
        end else begin
            if (pend_a) begin
                checks++;
                if (a_pcnt !== pe.pcnt || a_lcnt !== pe.lcnt) begin
                    errors++;
                    $display("FAIL a_counters: pcnt=%0d lcnt=%0d, required pcnt=%0d lcnt=%0d",
                             a_pcnt, a_lcnt, pe.pcnt, pe.lcnt);
                end
                pend_a = 0;
            end
            if (a_raw_valid) begin
                run_a++;
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL a_unexpected: data 0x%0h emitted, required no output",
                             a_raw_data);
                end else begin
                    pe = qa.pop_front();
                    if (a_raw_data !== pe.data || a_raw_sof !== pe.user ||
                        a_raw_eol !== pe.last) begin
                        errors++;
                        $display("FAIL a_word: data 0x%0h sof %0b eol %0b, required 0x%0h %0b %0b",
                                 a_raw_data, a_raw_sof, a_raw_eol, pe.data, pe.user, pe.last);
                    end
                    pend_a = 1;
                end
            end else if (run_a != 0) begin
                last_run_a = run_a;
                run_a      = 0;
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        exp_t eb;
        if (rst_n) begin
`ifdef AXIS2RAW_NOBP_EN
            if (b_raw_valid) begin
                checks++;
                if (seen_b && b_raw_data <= last_b) begin
                    errors++;
                    $display("FAIL b_order: data 0x%0h after 0x%0h, required increasing",
                             b_raw_data, last_b);
                end
                seen_b = 1;
                last_b = b_raw_data;
                nb++;
            end
`else
            if (!b_tready) begin
                checks++;
                if (b_level !== 5'd16) begin
                    errors++;
                    $display("FAIL b_tready: low at level %0d, required level 16", b_level);
                end else begin
                    saw_b_stall = 1;
                end
            end
            if (b_raw_valid) begin
                checks++;
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL b_unexpected: data 0x%0h, required no output", b_raw_data);
                end else begin
                    eb = qb.pop_front();
                    if (b_raw_data !== eb.data) begin
                        errors++;
                        $display("FAIL b_word: data 0x%0h, required 0x%0h", b_raw_data, eb.data);
                    end
                end
            end
`endif
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_tab[0] = '{8'h60, 1'b0, 1'b1, 20'd1, 11'd0};
        frame_tab[1] = '{8'h61, 1'b0, 1'b0, 20'd2, 11'd0};
        frame_tab[2] = '{8'h62, 1'b0, 1'b0, 20'd3, 11'd0};
        frame_tab[3] = '{8'h63, 1'b1, 1'b0, 20'd4, 11'd1};
        frame_tab[4] = '{8'h64, 1'b0, 1'b0, 20'd5, 11'd1};
        frame_tab[5] = '{8'h65, 1'b0, 1'b0, 20'd6, 11'd1};
        frame_tab[6] = '{8'h66, 1'b0, 1'b0, 20'd7, 11'd1};
        frame_tab[7] = '{8'h67, 1'b1, 1'b0, 20'd8, 11'd2};
        frame_tab[8] = '{8'h68, 1'b0, 1'b1, 20'd1, 11'd0};
        frame_tab[9] = '{8'h69, 1'b1, 1'b0, 20'd2, 11'd1};

        rst_n = 1'b0;
        a_tdata = 0; a_tvalid = 0; a_tlast = 0; a_tuser = 0;
        b_tdata = 0; b_tvalid = 0; b_tlast = 0; b_tuser = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        chk("reset_raw_valid", 32'(a_raw_valid), 32'd0);
        chk("reset_raw_data", 32'(a_raw_data), 32'd0);
        chk("reset_pcnt", 32'(a_pcnt), 32'd0);
        chk("reset_lcnt", 32'(a_lcnt), 32'd0);
        chk("reset_level", 32'(a_level), 32'd0);
        chk("reset_tready", 32'(a_tready), 32'd1);
        chk("reset_overflow", 32'(a_ovf), 32'd0);

        // Threshold burst: nothing leaves below the start level, then 8 contiguous words
        for (int i = 0; i < 7; i++) push_am(8'h10 + 8'(i), 1'b0, 1'b0, $urandom_range(0, 2));
        repeat (3) begin @(posedge clk); #1; end
        chk("below_start_level", 32'(a_level), 32'd7);
        chk("below_start_valid", 32'(a_raw_valid), 32'd0);
        push_am(8'h17, 1'b0, 1'b0, $urandom_range(0, 2));
        drain_a();
        chk("burst_run_length", 32'(last_run_a), 32'd8);
        chk("burst_level_after", 32'(a_level), 32'd0);

        // Short-line flush
        last_run_a = 0;
        push_am(8'hA0, 1'b0, 1'b0, $urandom_range(0, 2));
        push_am(8'hA1, 1'b0, 1'b0, $urandom_range(0, 2));
        push_am(8'hA2, 1'b1, 1'b0, $urandom_range(0, 2));
        drain_a();
        chk("flush_run_length", 32'(last_run_a), 32'd3);
        chk("flush_lcnt", 32'(a_lcnt), 32'd1);

        // Frame markers from the vector table
        for (int i = 0; i < 10; i++) begin
            push_a(frame_tab[i].data, frame_tab[i].last, frame_tab[i].user,
                   frame_tab[i].pcnt, frame_tab[i].lcnt, $urandom_range(0, 2));
        end
        mpa = 20'd2;
        mla = 11'd1;
        drain_a();
        chk("frame_pcnt_end", 32'(a_pcnt), 32'd2);

        // Full / backpressure (or drop mode) on the START_LEVEL=16 instance
        for (int i = 0; i < 20; i++) push_b(8'h20 + 8'(i));
        drain_b();
`ifdef AXIS2RAW_NOBP_EN
        chk("drop_overflow", 32'(b_ovf), 32'd1);
        chk("drop_some_lost", 32'(nb >= 16 && nb < 20), 32'd1);
`else
        chk("bp_overflow", 32'(b_ovf), 32'd0);
        chk("bp_stall_seen", 32'(saw_b_stall), 32'd1);
`endif

        // Async reset mid-burst, then a clean refill
        for (int i = 0; i < 8; i++) push_am(8'h40 + 8'(i), 1'b0, 1'b0, 0);
        begin
            int n;
            n = 0;
            while (!a_raw_valid && n < 50) begin @(posedge clk); #1; n++; end
            chk("reset_burst_started", 32'(a_raw_valid), 32'd1);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_valid", 32'(a_raw_valid), 32'd0);
        chk("midreset_level", 32'(a_level), 32'd0);
        chk("midreset_pcnt", 32'(a_pcnt), 32'd0);
        qa.delete();
        mpa = 0;
        mla = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        last_run_a = 0;
        for (int i = 0; i < 8; i++) push_am(8'h50 + 8'(i), 1'b0, 1'b0, $urandom_range(0, 2));
        drain_a();
        chk("refill_run_length", 32'(last_run_a), 32'd8);
        chk("refill_pcnt", 32'(a_pcnt), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
